// File: rtl/vrlp_to_compressed_vita_demux_if.sv
// Stream bundle for the VRLP deframer/demux:
// one 64-bit VRLP input, NUM_CH CHDR outputs sharing data/last.
interface vrlp_to_compressed_vita_demux_if #(
  parameter int NUM_CH = 4
);
  logic [63:0]       i_tdata;
  logic              i_tlast;
  logic              i_tvalid;
  logic              i_tready;
  logic [63:0]       o_tdata;
  logic              o_tlast;
  logic [NUM_CH-1:0] o_tvalid;
  logic [NUM_CH-1:0] o_tready;

  modport slave (
    input  i_tdata, i_tlast, i_tvalid, o_tready,
    output i_tready, o_tdata, o_tlast, o_tvalid
  );

  modport master (
    output i_tdata, i_tlast, i_tvalid, o_tready,
    input  i_tready, o_tdata, o_tlast, o_tvalid
  );
endinterface

// File: rtl/vrlp_to_compressed_vita_demux.sv
// VRLP deframer + CHDR channel demux, zero-latency pass-through.
// Define VRLP_SEQ_CHECK_EN to enable VRLP frame-count checking.
module vrlp_to_compressed_vita_demux #(
  parameter int NUM_CH     = 4,
  parameter int CH_SEL_LSB = 0,
  parameter int ERR_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  vrlp_to_compressed_vita_demux_if.slave bus,
  output logic [ERR_W-1:0] frame_err_cnt,
  output logic [ERR_W-1:0] seq_err_cnt
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CHDR_HDR = 3'd1;
  localparam logic [2:0] S_BODY     = 3'd2;
  localparam logic [2:0] S_TRAILER  = 3'd3;
  localparam logic [2:0] S_DROP     = 3'd4;

  logic [2:0]      state, state_nxt;
  logic [19:0]     vlen;
  logic [CH_W-1:0] ch_q, hdr_ch, sel_ch;
  logic [13:0]     rem, cw;
  logic [15:0]     clen;
  logic            is_vrlp, is_vend;
  logic            ch_ok, len_ok, hdr_ok;
  logic            fwd, xfer, ferr, hdr_acc;

  always_comb begin
    is_vrlp = bus.i_tdata[63:32] == 32'h5652_4C50;
    is_vend = bus.i_tdata[63:32] == 32'h5645_4E44;
    clen    = bus.i_tdata[47:32];
    cw      = 14'((17'(clen) + 17'd7) >> 3);
    hdr_ch  = bus.i_tdata[CH_SEL_LSB +: CH_W];
    ch_ok   = 32'(hdr_ch) < 32'(NUM_CH);
    len_ok  = vlen == (({6'd0, cw} << 1) + 20'd4);
    hdr_ok  = ch_ok && len_ok && (cw != 14'd0);
  end

  always_comb begin
    fwd    = 1'b0;
    sel_ch = ch_q;
    if (state == S_CHDR_HDR && hdr_ok) begin
      fwd    = 1'b1;
      sel_ch = hdr_ch;
    end else if (state == S_BODY) begin
      fwd = 1'b1;
    end
  end

  // Unselected channels' ready never reaches i_tready.
  always_comb begin
    bus.o_tvalid = '0;
    bus.i_tready = 1'b1;
    if (fwd) begin
      bus.o_tvalid[sel_ch] = bus.i_tvalid;
      bus.i_tready         = bus.o_tready[sel_ch];
    end
  end

  assign bus.o_tdata = bus.i_tdata;

  // An early i_tlast always closes the downstream packet.
  always_comb begin
    bus.o_tlast = 1'b0;
    if (state == S_CHDR_HDR && hdr_ok)
      bus.o_tlast = (cw == 14'd1) | bus.i_tlast;
    else if (state == S_BODY)
      bus.o_tlast = (rem == 14'd1) | bus.i_tlast;
  end

  assign xfer    = bus.i_tvalid & bus.i_tready;
  assign hdr_acc = xfer && state == S_IDLE
                   && is_vrlp && !bus.i_tlast;

  always_comb begin
    state_nxt = state;
    ferr      = 1'b0;
    if (xfer) begin
      unique case (state)
        S_IDLE: begin
          if (is_vrlp && !bus.i_tlast) begin
            state_nxt = S_CHDR_HDR;
          end else begin
            ferr      = 1'b1;
            state_nxt = bus.i_tlast ? S_IDLE : S_DROP;
          end
        end
        S_CHDR_HDR: begin
          if (!hdr_ok) begin
            ferr      = 1'b1;
            state_nxt = bus.i_tlast ? S_IDLE : S_DROP;
          end else if (bus.i_tlast) begin
            ferr      = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            state_nxt = (cw == 14'd1) ? S_TRAILER : S_BODY;
          end
        end
        S_BODY: begin
          if (bus.i_tlast) begin
            ferr      = 1'b1;
            state_nxt = S_IDLE;
          end else if (rem == 14'd1) begin
            state_nxt = S_TRAILER;
          end
        end
        S_TRAILER: begin
          if (!(is_vend && bus.i_tlast)) begin
            ferr      = 1'b1;
            state_nxt = bus.i_tlast ? S_IDLE : S_DROP;
          end else begin
            state_nxt = S_IDLE;
          end
        end
        S_DROP: begin
          if (bus.i_tlast) state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      vlen          <= '0;
      ch_q          <= '0;
      rem           <= '0;
      frame_err_cnt <= '0;
    end else if (clear) begin
      state         <= S_IDLE;
      frame_err_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (hdr_acc) vlen <= bus.i_tdata[19:0];
      if (xfer && state == S_CHDR_HDR && hdr_ok) begin
        ch_q <= hdr_ch;
        rem  <= cw - 14'd1;
      end
      if (xfer && state == S_BODY) rem <= rem - 14'd1;
      if (ferr) frame_err_cnt <= frame_err_cnt + ERR_W'(1);
    end
  end

`ifdef VRLP_SEQ_CHECK_EN
  logic [11:0] fcnt, exp_fcnt;
  logic        seeded, seq_err;

  assign fcnt    = bus.i_tdata[31:20];
  assign seq_err = hdr_acc && seeded && (fcnt != exp_fcnt);

  // First header after reset/clear only seeds the expectation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_fcnt    <= '0;
      seeded      <= 1'b0;
      seq_err_cnt <= '0;
    end else if (clear) begin
      exp_fcnt    <= '0;
      seeded      <= 1'b0;
      seq_err_cnt <= '0;
    end else if (hdr_acc) begin
      exp_fcnt <= fcnt + 12'd1;
      seeded   <= 1'b1;
      if (seq_err) seq_err_cnt <= seq_err_cnt + ERR_W'(1);
    end
  end
`else
  assign seq_err_cnt = '0;
`endif

endmodule

// File: tb/tb_vrlp_to_compressed_vita_demux.sv
// Scoreboard bench for vrlp_to_compressed_vita_demux.
// Expected CHDR words are queued when frames are built.
module tb_vrlp_to_compressed_vita_demux;
  localparam int NUM_CH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] frame_err_cnt, seq_err_cnt;

  vrlp_to_compressed_vita_demux_if #(.NUM_CH(NUM_CH)) bus ();

  vrlp_to_compressed_vita_demux #(
    .NUM_CH(NUM_CH), .CH_SEL_LSB(0), .ERR_W(16)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .clear(clear),
    .bus(bus),
    .frame_err_cnt(frame_err_cnt),
    .seq_err_cnt(seq_err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  ch;
    logic [63:0] d;
    logic        l;
  } exp_t;

  exp_t        sb[$];
  logic [64:0] frm[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          exp_ferr = 0;
  int          exp_seq = 0;
  logic [11:0] fcnt_g = 12'd0;
  bit          rnd_rdy = 1'b0;

  always @(posedge clk) begin
    #1;
    bus.o_tready = rnd_rdy ? 4'($urandom) : '1;
  end

  always @(negedge clk) begin : mon
    exp_t e;
    if (reset_n && !clear) begin
      n_cmp++;
      if ($countones(bus.o_tvalid) > 1) begin
        n_err++;
        $display("FAIL onehot: o_tvalid=%b, need <=1 bit",
                 bus.o_tvalid);
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (bus.o_tvalid[c]) begin
          n_cmp++;
          if (bus.i_tready !== bus.o_tready[c]) begin
            n_err++;
            $display("FAIL i_tready: got %b, need %b (ch%0d)",
                     bus.i_tready, bus.o_tready[c], c);
          end
          if (bus.o_tready[c]) begin
            n_cmp++;
            if (sb.size() == 0) begin
              n_err++;
              $display("FAIL unexpected: ch%0d data=%h last=%b",
                       c, bus.o_tdata, bus.o_tlast);
            end else begin
              e = sb.pop_front();
              if ({2'(c), bus.o_tdata, bus.o_tlast} !== e) begin
                n_err++;
                $display("FAIL out: got ch%0d %h l%b, need ch%0d %h l%b",
                         c, bus.o_tdata, bus.o_tlast, e.ch, e.d, e.l);
              end
            end
          end
        end
      end
    end
  end

  task automatic send_frm();
    logic [64:0] w;
    int k;
    while (frm.size() != 0) begin
      w = frm.pop_front();
      bus.i_tdata  = w[63:0];
      bus.i_tlast  = w[64];
      bus.i_tvalid = 1'b1;
      k = 0;
      @(negedge clk);
      while (!bus.i_tready && k < 2000) begin
        @(negedge clk);
        k++;
      end
      if (!bus.i_tready) begin
        n_cmp++;
        n_err++;
        $display("FAIL send_timeout: i_tready=0, need 1");
      end
      @(posedge clk);
      #1;
    end
    bus.i_tvalid = 1'b0;
    bus.i_tlast  = 1'b0;
  endtask

  task automatic good_frame(input logic [63:0] hdr);
    int nb, cw;
    logic [63:0] p;
    nb = int'(hdr[47:32]);
    cw = (nb + 7) / 8;
    frm.push_back({1'b0, 32'h5652_4C50, fcnt_g, 20'(2 * cw + 4)});
    fcnt_g = fcnt_g + 12'd1;
    frm.push_back({1'b0, hdr});
    sb.push_back({hdr[1:0], hdr, cw == 1});
    for (int i = 1; i < cw; i++) begin
      p = {$urandom, $urandom};
      frm.push_back({1'b0, p});
      sb.push_back({hdr[1:0], p, i == cw - 1});
    end
    frm.push_back({1'b1, 32'h5645_4E44, $urandom});
    send_frm();
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 1000) begin
      @(posedge clk);
      k++;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    fcnt_g = 12'd0;
  endtask

  task automatic test_reset();
    n_cmp++;
    if (bus.o_tvalid !== '0) begin
      n_err++;
      $display("FAIL rst_tvalid: got %b, need 0", bus.o_tvalid);
    end
    n_cmp++;
    if (bus.i_tready !== 1'b1) begin
      n_err++;
      $display("FAIL rst_tready: got %b, need 1", bus.i_tready);
    end
    n_cmp++;
    if (frame_err_cnt !== 16'd0 || seq_err_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL rst_cnt: got %0d/%0d, need 0/0",
               frame_err_cnt, seq_err_cnt);
    end
  endtask

  task automatic test_basic();
    good_frame(64'hAABC_0010_DEAD_BEEF);
    drain();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL basic_left: %0d words, need 0", sb.size());
    end
    n_cmp++;
    if (frame_err_cnt !== 16'(exp_ferr)) begin
      n_err++;
      $display("FAIL basic_ferr: got %0d, need %0d",
               frame_err_cnt, exp_ferr);
    end
  endtask

  task automatic test_channels();
    rnd_rdy = 1'b1;
    for (int s = 0; s < 4; s++)
      good_frame({16'h1000, 16'(9 * s + 8), 16'h00C0, 16'(s)});
    for (int s = 3; s >= 0; s--)
      good_frame({16'h2000, 16'(8 * s + 3), 16'h0100, 16'(s)});
    drain();
    rnd_rdy = 1'b0;
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL chan_left: %0d words, need 0", sb.size());
    end
    n_cmp++;
    if (frame_err_cnt !== 16'(exp_ferr)) begin
      n_err++;
      $display("FAIL chan_ferr: got %0d, need %0d",
               frame_err_cnt, exp_ferr);
    end
  endtask

  task automatic test_len_mismatch();
    frm.push_back({1'b0, 32'h5652_4C50, fcnt_g, 20'd10});
    fcnt_g = fcnt_g + 12'd1;
    frm.push_back({1'b0, 64'h1000_0008_0000_0001});
    frm.push_back({1'b0, 64'h1111_2222_3333_4444});
    frm.push_back({1'b1, 64'h5645_4E44_0000_0000});
    send_frm();
    exp_ferr++;
    good_frame(64'h3000_0018_0000_0002);
    drain();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL len_left: %0d words, need 0", sb.size());
    end
    n_cmp++;
    if (frame_err_cnt !== 16'(exp_ferr)) begin
      n_err++;
      $display("FAIL len_ferr: got %0d, need %0d",
               frame_err_cnt, exp_ferr);
    end
  endtask

  task automatic test_bad_magic();
    frm.push_back({1'b0, 64'h1234_5678_0000_0008});
    frm.push_back({1'b0, 64'h5652_4C50_0000_0008});
    frm.push_back({1'b1, 64'h5645_4E44_0000_0000});
    send_frm();
    exp_ferr++;
    good_frame(64'h4000_0020_0000_0001);
    drain();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL magic_left: %0d words, need 0", sb.size());
    end
    n_cmp++;
    if (frame_err_cnt !== 16'(exp_ferr)) begin
      n_err++;
      $display("FAIL magic_ferr: got %0d, need %0d",
               frame_err_cnt, exp_ferr);
    end
  endtask

  task automatic test_early_end();
    frm.push_back({1'b0, 32'h5652_4C50, fcnt_g, 20'd12});
    fcnt_g = fcnt_g + 12'd1;
    frm.push_back({1'b0, 64'h5000_0020_0000_0001});
    sb.push_back({2'd1, 64'h5000_0020_0000_0001, 1'b0});
    frm.push_back({1'b1, 64'hFEED_FACE_0BAD_CAFE});
    sb.push_back({2'd1, 64'hFEED_FACE_0BAD_CAFE, 1'b1});
    send_frm();
    exp_ferr++;
    good_frame(64'h6000_0008_0000_0003);
    drain();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL early_left: %0d words, need 0", sb.size());
    end
    n_cmp++;
    if (frame_err_cnt !== 16'(exp_ferr)) begin
      n_err++;
      $display("FAIL early_ferr: got %0d, need %0d",
               frame_err_cnt, exp_ferr);
    end
  endtask

  task automatic test_clear();
    pulse_clear();
    exp_ferr = 0;
    exp_seq  = 0;
    n_cmp++;
    if (frame_err_cnt !== 16'd0 || seq_err_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL clear_cnt: got %0d/%0d, need 0/0",
               frame_err_cnt, seq_err_cnt);
    end
  endtask

  task automatic test_seq();
    logic [11:0] seq_a[4];
    seq_a = '{12'd0, 12'd1, 12'd3, 12'd4};
    pulse_clear();
    for (int i = 0; i < 4; i++) begin
      fcnt_g = seq_a[i];
      good_frame({16'h7000, 16'd16, 16'h0000, 16'(i)});
    end
`ifdef VRLP_SEQ_CHECK_EN
    exp_seq = 1;
`endif
    drain();
    n_cmp++;
    if (seq_err_cnt !== 16'(exp_seq) || sb.size() != 0) begin
      n_err++;
      $display("FAIL seq_gap: got %0d left %0d, need %0d left 0",
               seq_err_cnt, sb.size(), exp_seq);
    end
    pulse_clear();
    exp_seq = 0;
    fcnt_g = 12'd4095;
    good_frame(64'h7100_0010_0000_0002);
    good_frame(64'h7200_0010_0000_0003);
    drain();
    n_cmp++;
    if (seq_err_cnt !== 16'(exp_seq) || sb.size() != 0) begin
      n_err++;
      $display("FAIL seq_wrap: got %0d left %0d, need %0d left 0",
               seq_err_cnt, sb.size(), exp_seq);
    end
    n_cmp++;
    if (frame_err_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL seq_ferr: got %0d, need 0", frame_err_cnt);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.i_tdata  = '0;
    bus.i_tlast  = 1'b0;
    bus.i_tvalid = 1'b0;
    bus.o_tready = '1;
    repeat (4) @(posedge clk);
    #1;
    test_reset();
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_channels();
    test_len_mismatch();
    test_bad_magic();
    test_early_end();
    test_clear();
    test_seq();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
